// File: rtl/instruction_prefetch_buffer.sv
// Instruction prefetch buffer: credit-limited in-order fetch into a DEPTH-entry {instr, pc} FIFO,
// with redirect flush and stale-response dropping. Optional same-cycle bypass via PREFETCH_BYPASS_EN.
module instruction_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus_4,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned CW      = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   pc_mem_q    [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic          run_q;

    logic          req_fire;
    logic          resp_in;
    logic          resp_live;
    logic          fifo_empty;
    logic          bypass_act;
    logic          bypass_take;
    logic          pop;
    logic          push_we;
    logic [CW:0]   inflight;
    logic [31:0]   redirect_aligned;
    logic          unused_redirect_bits;

    assign unused_redirect_bits = ^redirect_pc[1:0];
    assign redirect_aligned     = {redirect_pc[31:2], 2'b00};

    // run_q holds off the first request until one edge after reset release.
    assign inflight      = {1'b0, count_q} + {1'b0, outst_q};
    assign mem_req_valid = run_q && (inflight < DEPTH_W);
    assign mem_req_addr  = fetch_pc_q;
    assign req_fire      = mem_req_valid && mem_req_ready;

    // A response with nothing in flight (e.g. straggler across reset) is ignored.
    assign resp_in    = mem_resp_valid && (outst_q != '0);
    assign resp_live  = resp_in && (drop_q == '0);
    assign fifo_empty = (count_q == '0);

`ifdef PREFETCH_BYPASS_EN
    assign bypass_act = run_q && fifo_empty && resp_live;
`else
    assign bypass_act = 1'b0;
`endif

    assign bypass_take = bypass_act && instr_ready;
    assign pop         = instr_ready && !fifo_empty;

    always_comb begin
        instr_valid = 1'b0;
        instr       = NOP;
        pc          = '0;
        pc_plus_4   = '0;
        if (bypass_act) begin
            instr_valid = 1'b1;
            instr       = mem_resp_data;
            pc          = resp_pc_q;
            pc_plus_4   = resp_pc_q + 32'd4;
        end else if (!fifo_empty) begin
            instr_valid = 1'b1;
            instr       = instr_mem_q[rd_ptr_q];
            pc          = pc_mem_q[rd_ptr_q];
            pc_plus_4   = pc_mem_q[rd_ptr_q] + 32'd4;
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        push_we    = resp_live && !bypass_take;

        if (req_fire && !resp_in) begin
            outst_d = outst_q + CW'(1);
        end else if (!req_fire && resp_in) begin
            outst_d = outst_q - CW'(1);
        end

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (resp_in && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end
        if (push_we || bypass_take) begin
            resp_pc_d = resp_pc_q + 32'd4;
        end
        if (push_we) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_we, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Everything still in flight after this edge belongs to the old path and must be dropped.
        if (redirect) begin
            push_we    = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            drop_d     = outst_d;
            fetch_pc_d = redirect_aligned;
            resp_pc_d  = redirect_aligned;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            run_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            run_q      <= 1'b1;
        end
    end

    // Storage carries no reset; validity is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_we) begin
            instr_mem_q[wr_ptr_q] <= mem_resp_data;
            pc_mem_q[wr_ptr_q]    <= resp_pc_q;
        end
    end

endmodule

// File: tb/tb_instruction_prefetch_buffer.sv
// Directed bench for instruction_prefetch_buffer with a 1-cycle memory model and an expected-pop queue.
module tb_instruction_prefetch_buffer;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    instruction_prefetch_buffer #(.DEPTH(4), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .pc             (pc),
        .pc_plus_4      (pc_plus_4),
        .instr_ready    (instr_ready),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] memq [$];
    logic [63:0] expq [$];
    logic [31:0] exp_fetch;
    int          acc_cnt;
    int          pop_cnt;
    logic [31:0] first_pop_pc;
    logic [31:0] fifth_addr;
    logic [31:0] wrap_p4;
    logic        wrap_seen;
    logic        resp_en;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h00A0_0093;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Evaluated just before the active edge, using the values the DUT will see at that edge.
    task automatic model_edge();
        logic [63:0] e;
        if (!rst_n) return;
        if (redirect) begin
            expq.delete();
        end else if (instr_valid && instr_ready) begin
            if (expq.size() == 0) begin
                chk("spurious_instr_valid", 32'(instr_valid), 32'd0);
            end else begin
                e = expq.pop_front();
                chk("pop_pc", pc, e[63:32]);
                chk("pop_instr", instr, e[31:0]);
                chk("pop_pc_plus_4", pc_plus_4, e[63:32] + 32'd4);
                if (pop_cnt == 0) first_pop_pc = pc;
                if (pc == 32'hFFFF_FFFC) begin
                    wrap_p4   = pc_plus_4;
                    wrap_seen = 1'b1;
                end
                pop_cnt++;
            end
        end
        if (mem_req_valid && mem_req_ready) begin
            chk("req_addr", mem_req_addr, exp_fetch);
            memq.push_back(mem_req_addr);
            if (!redirect) expq.push_back({mem_req_addr, mem_word(mem_req_addr)});
            if (acc_cnt == 4) fifth_addr = mem_req_addr;
            acc_cnt++;
            exp_fetch = mem_req_addr + 32'd4;
        end
        if (redirect) exp_fetch = {redirect_pc[31:2], 2'b00};
    endtask

    task automatic cycle();
        @(negedge clk);
        model_edge();
        @(posedge clk);
        #1;
        if (resp_en && memq.size() > 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem_word(memq.pop_front());
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = '0;
        end
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst_n          = 1'b0;
        redirect       = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hDEAD_BEEF;
        #1;
        chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr_nop", instr, 32'h0000_0013);
        chk("rst_pc", pc, 32'd0);
        chk("rst_pc_plus_4", pc_plus_4, 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n          = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        memq.delete();
        expq.delete();
        exp_fetch = RST_PC;
        acc_cnt   = 0;
        pop_cnt   = 0;
        #1;
    endtask

    task automatic wait_acc(input int n, input int limit);
        for (int i = 0; i < limit && acc_cnt < n; i++) cycle();
        chk("accept_budget", 32'(acc_cnt >= n), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = '0;
        instr_ready = 1'b1; redirect = 1'b0; redirect_pc = '0; resp_en = 1'b1;
        wrap_seen = 1'b0; wrap_p4 = '1; first_pop_pc = '1; fifth_addr = '1;
        exp_fetch = RST_PC; acc_cnt = 0; pop_cnt = 0;

        // Reset release and sequential streaming
        do_reset();
        cycle();
        chk("first_req_valid", 32'(mem_req_valid), 32'd1);
        chk("first_req_addr", mem_req_addr, RST_PC);
        repeat (24) cycle();
        chk("stream_pops", 32'(pop_cnt >= 16), 32'd1);
        chk("stream_first_pc", first_pop_pc, RST_PC);

        // Decode stalled from reset: credit limit fills the FIFO
        do_reset();
        instr_ready = 1'b0;
        repeat (16) cycle();
        chk("full_accepts", 32'(acc_cnt), 32'd4);
        chk("full_req_valid", 32'(mem_req_valid), 32'd0);
        chk("full_instr_valid", 32'(instr_valid), 32'd1);
        chk("full_head_pc", pc, 32'd0);
        instr_ready = 1'b1;
        repeat (12) cycle();
        chk("resume_pops", 32'(pop_cnt >= 5), 32'd1);
        chk("resume_addr", fifth_addr, 32'h0000_0010);

        // Three outstanding, held request, then redirect to an unaligned target
        do_reset();
        resp_en = 1'b0;
        wait_acc(3, 20);
        mem_req_ready = 1'b0;
        cycle();
        chk("hold_addr_a", mem_req_addr, 32'h0000_000C);
        cycle();
        chk("hold_addr_b", mem_req_addr, 32'h0000_000C);
        chk("hold_valid", 32'(mem_req_valid), 32'd1);
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        cycle();
        redirect = 1'b0;
        chk("redir_addr", mem_req_addr, 32'h0000_0100);
        chk("redir_instr_valid", 32'(instr_valid), 32'd0);
        mem_req_ready = 1'b1; resp_en = 1'b1; pop_cnt = 0;
        repeat (14) cycle();
        chk("redir_first_pop", first_pop_pc, 32'h0000_0100);
        chk("redir_pops", 32'(pop_cnt >= 4), 32'd1);

        // Back-to-back redirects with requests accepted in redirect cycles
        resp_en = 1'b0;
        repeat (3) cycle();
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        cycle();
        redirect_pc = 32'h0000_0300;
        cycle();
        redirect = 1'b0;
        chk("b2b_addr", mem_req_addr, 32'h0000_0300);
        chk("b2b_instr_valid", 32'(instr_valid), 32'd0);
        pop_cnt = 0; resp_en = 1'b1;
        repeat (20) cycle();
        chk("b2b_first_pop", first_pop_pc, 32'h0000_0300);

        // Address wrap at the top of the address space
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        cycle();
        redirect = 1'b0; wrap_seen = 1'b0;
        repeat (16) cycle();
        chk("wrap_seen", 32'(wrap_seen), 32'd1);
        chk("wrap_pc_plus_4", wrap_p4, 32'h0000_0000);

        // Reset with entries queued and requests in flight
        instr_ready = 1'b0;
        repeat (2) cycle();
        resp_en = 1'b0;
        repeat (4) cycle();
        chk("pre_reset_instr_valid", 32'(instr_valid), 32'd1);
        do_reset();
        chk("post_reset_instr_valid", 32'(instr_valid), 32'd0);
        cycle();
        chk("post_reset_req_valid", 32'(mem_req_valid), 32'd1);
        chk("post_reset_req_addr", mem_req_addr, RST_PC);
        instr_ready = 1'b1; resp_en = 1'b1;
        repeat (10) cycle();
        chk("post_reset_first_pop", first_pop_pc, RST_PC);

        // Response into an empty FIFO: bypass or one-cycle latency
        do_reset();
        resp_en = 1'b0;
        wait_acc(1, 10);
        mem_req_ready = 1'b0; resp_en = 1'b1;
        cycle();
        chk("resp_data_driven", mem_resp_data, 32'h00A0_0093);
`ifdef PREFETCH_BYPASS_EN
        chk("bypass_instr_valid", 32'(instr_valid), 32'd1);
        chk("bypass_instr", instr, 32'h00A0_0093);
`else
        chk("latency_instr_valid", 32'(instr_valid), 32'd0);
        chk("latency_instr", instr, 32'h0000_0013);
`endif
        cycle();
        cycle();
        chk("single_pop_count", 32'(pop_cnt), 32'd1);
        chk("single_empty_after", 32'(instr_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
